qspi_fb_arbiter: RTL and testbench

Sole owner of the framebuffer QSPI RAM pins. After reset it runs the RAM init sequence, then shares the RAM between two requesters:
- Read bursts from the VGA scan-out path (deadline-critical, high priority).
- Single-pixel writes from the Mandelbrot compute engine, buffered in a small write FIFO (low priority).

---
 rtl/qspi_fb_arbiter.sv | 273 +++++++++++++++++++++++++++
 tb/tb_qspi_fb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_fb_arbiter.sv
// Framebuffer QSPI RAM owner: runs the RAM init sequence, then arbitrates VGA read bursts
// (high priority) against FIFO-buffered pixel writes. Optional macro: QSPI_WRITE_BURST_EN.
module qspi_fb_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_BURST = 8,
  parameter int READ_DUMMY = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [3:0]            rd_data,
  output logic                  rd_valid,
  output logic                  rd_overrun,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]            wr_data,
  output logic [3:0]            data_out,
  output logic [3:0]            data_dir,
  input  logic [3:0]            data_in,
  output logic                  chip_enable
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [7:0]     DUMMY_LAST = 8'(READ_DUMMY - 1);
  localparam logic [7:0]     RDATA_LAST = 8'(READ_BURST - 1);
  localparam logic [PTR_W:0] FIFO_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    INIT_GAP, INIT_CMD, IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, CE_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            init_idx_q, init_idx_d;
  logic                  init_done_q, init_done_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  op_rd_q, op_rd_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]            rd_data_q;
  logic                  rd_valid_q, rd_overrun_q;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [3:0]            fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push, pop, fifo_empty;

`ifdef QSPI_WRITE_BURST_EN
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] BURST_CAP = (PTR_W+1)'(FIFO_DEPTH - 1);
  logic [PTR_W:0]   burst_q, burst_d;
  logic [PTR_W-1:0] nxt_ptr;
  assign nxt_ptr = rptr_q + 1'b1;
`endif

  logic       launch_rd, read_busy, rd_accept;
  logic [7:0] init_byte, cmd_byte;
  logic [23:0] addr_pad;
  logic [3:0] addr_nib;

  assign init_done  = init_done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_overrun = rd_overrun_q;

  assign fifo_empty = (count_q == '0);
  assign wr_ready   = (count_q != FIFO_FULL);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_q == WDATA);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    init_byte = 8'h35;
    case (init_idx_q)
      2'd0:    init_byte = 8'h66;
      2'd1:    init_byte = 8'h99;
      default: init_byte = 8'h35;
    endcase
    cmd_byte = op_rd_q ? 8'hEB : 8'h38;
    addr_pad = 24'(cur_addr_q);
    addr_nib = addr_pad[3:0];
    case (cnt_q[2:0])
      3'd0:    addr_nib = addr_pad[23:20];
      3'd1:    addr_nib = addr_pad[19:16];
      3'd2:    addr_nib = addr_pad[15:12];
      3'd3:    addr_nib = addr_pad[11:8];
      3'd4:    addr_nib = addr_pad[7:4];
      default: addr_nib = addr_pad[3:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    op_rd_d     = op_rd_q;
    cur_addr_d  = cur_addr_q;
    launch_rd   = 1'b0;
    chip_enable = 1'b1;
    data_dir    = 4'h0;
    data_out    = 4'h0;
`ifdef QSPI_WRITE_BURST_EN
    burst_d     = burst_q;
`endif
    case (state_q)
      INIT_GAP: begin
        if (cnt_q == 8'd1) begin
          cnt_d = '0;
          if (init_idx_q == 2'd3) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = INIT_CMD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT_CMD: begin
        chip_enable = 1'b0;
        data_dir    = 4'h1;
        data_out    = {3'b000, init_byte[3'd7 - cnt_q[2:0]]};
        if (cnt_q == 8'd7) begin
          cnt_d      = '0;
          init_idx_d = init_idx_q + 1'b1;
          state_d    = INIT_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // CE_GAP arbitrates too, so back-to-back transactions see a single CE-high cycle
      IDLE, CE_GAP: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (init_done_q && rd_pending_q) begin
          state_d    = CMD;
          op_rd_d    = 1'b1;
          cur_addr_d = rd_addr_q;
          launch_rd  = 1'b1;
        end else if (init_done_q && !fifo_empty) begin
          state_d    = CMD;
          op_rd_d    = 1'b0;
          cur_addr_d = fifo_addr_q[rptr_q];
        end
      end
      CMD: begin
        chip_enable = 1'b0;
        data_dir    = 4'hF;
        data_out    = (cnt_q == 8'd0) ? cmd_byte[7:4] : cmd_byte[3:0];
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADDR: begin
        chip_enable = 1'b0;
        data_dir    = 4'hF;
        data_out    = addr_nib;
        if (cnt_q == 8'd5) begin
          cnt_d   = '0;
          state_d = op_rd_q ? DUMMY : WDATA;
`ifdef QSPI_WRITE_BURST_EN
          burst_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DUMMY: begin
        chip_enable = 1'b0;
        if (cnt_q == DUMMY_LAST) begin
          cnt_d   = '0;
          state_d = RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RDATA: begin
        chip_enable = 1'b0;
        if (cnt_q == RDATA_LAST) begin
          cnt_d   = '0;
          state_d = CE_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WDATA: begin
        chip_enable = 1'b0;
        data_dir    = 4'hF;
        data_out    = fifo_data_q[rptr_q];
`ifdef QSPI_WRITE_BURST_EN
        if ((count_q > CNT_ONE) && (fifo_addr_q[nxt_ptr] == cur_addr_q + 1'b1) &&
            !rd_pending_q && (burst_q != BURST_CAP)) begin
          cur_addr_d = cur_addr_q + 1'b1;
          burst_d    = burst_q + 1'b1;
        end else begin
          state_d = CE_GAP;
        end
`else
        state_d = CE_GAP;
`endif
      end
      default: begin
        state_d = INIT_GAP;
        cnt_d   = 8'd1;
      end
    endcase

    read_busy    = op_rd_q && (state_q inside {CMD, ADDR, DUMMY, RDATA});
    rd_accept    = rd_req && !rd_pending_q && !read_busy;
    rd_pending_d = rd_accept ? 1'b1 : (launch_rd ? 1'b0 : rd_pending_q);
    rd_addr_d    = rd_accept ? rd_addr : rd_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= INIT_GAP;
      cnt_q        <= 8'd1;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      op_rd_q      <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 4'h0;
      rd_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      rd_pending_q <= rd_pending_d;
      op_rd_q      <= op_rd_d;
      count_q      <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      rd_valid_q   <= (state_q == RDATA);
      if (state_q == RDATA) rd_data_q <= data_in;
      rd_overrun_q <= rd_req && !rd_accept;
    end
  end

  always_ff @(posedge clk) begin
    rd_addr_q  <= rd_addr_d;
    cur_addr_q <= cur_addr_d;
`ifdef QSPI_WRITE_BURST_EN
    burst_q    <= burst_d;
`endif
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr;
      fifo_data_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_qspi_fb_arbiter.sv
// Directed bench for qspi_fb_arbiter: init sequence, quad read, FIFO writes, arbitration,
// mid-read reset and (optionally) write bursts, with hand-computed IO expectations.
module tb_qspi_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        rd_overrun;
  logic        wr_valid;
  logic        wr_ready;
  logic [23:0] wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  data_out;
  logic [3:0]  data_dir;
  logic [3:0]  data_in;
  logic        chip_enable;

  int nvec = 0;
  int nerr = 0;

  logic [23:0] t3a [5] = '{24'h00A5C3, 24'h000001, 24'h123456, 24'hFEDCBA, 24'h000040};
  logic [3:0]  t3d [5] = '{4'h3, 4'hA, 4'h5, 4'hF, 4'h9};

  always #5 clk = ~clk;

  qspi_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_overrun(rd_overrun), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .data_out(data_out), .data_dir(data_dir),
    .data_in(data_in), .chip_enable(chip_enable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic io(input string tag, input logic ce, input logic [3:0] dir, input logic [3:0] dout);
    chk({tag, ".ce"},  32'(chip_enable), 32'(ce));
    chk({tag, ".dir"}, 32'(data_dir),    32'(dir));
    chk({tag, ".out"}, 32'(data_out),    32'(dout));
  endtask

  task automatic check_rst(input string tag);
    io(tag, 1'b1, 4'h0, 4'h0);
    chk({tag, ".rd_valid"},   32'(rd_valid),   0);
    chk({tag, ".rd_data"},    32'(rd_data),    0);
    chk({tag, ".rd_overrun"}, 32'(rd_overrun), 0);
    chk({tag, ".init_done"},  32'(init_done),  0);
    chk({tag, ".wr_ready"},   32'(wr_ready),   1);
  endtask

  task automatic check_init(input string tag);
    logic [7:0] ib [3];
    ib[0] = 8'h66; ib[1] = 8'h99; ib[2] = 8'h35;
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 8; b++) begin
        io($sformatf("%s_c%0d_b%0d", tag, c, b), 1'b0, 4'h1, {3'b000, ib[c][7-b]});
        @(negedge clk);
      end
      for (int g = 0; g < 2; g++) begin
        io($sformatf("%s_c%0d_gap%0d", tag, c, g), 1'b1, 4'h0, 4'h0);
        chk($sformatf("%s_c%0d_gap%0d.init_done", tag, c, g), 32'(init_done), 0);
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, 32'(init_done), 1);
  endtask

  task automatic wait_ce_low(input string tag, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (chip_enable && n < maxc);
    chk({tag, ".found"}, 32'(!chip_enable), 1);
  endtask

  // Entered on the first CMD cycle; returns on the CE_GAP cycle.
  task automatic read_txn(input string tag, input logic [23:0] a, input logic [3:0] base);
    io({tag, "_cmd0"}, 1'b0, 4'hF, 4'hE); @(negedge clk);
    io({tag, "_cmd1"}, 1'b0, 4'hF, 4'hB); @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      io($sformatf("%s_addr%0d", tag, i), 1'b0, 4'hF, a[23-4*i -: 4]); @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      io($sformatf("%s_dummy%0d", tag, i), 1'b0, 4'h0, 4'h0); @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      io($sformatf("%s_rdata%0d", tag, k), 1'b0, 4'h0, 4'h0);
      chk($sformatf("%s_rvld%0d", tag, k), 32'(rd_valid), (k != 0) ? 1 : 0);
      if (k != 0) chk($sformatf("%s_rd%0d", tag, k - 1), 32'(rd_data), 32'(base + 4'(k - 1)));
      data_in = base + 4'(k);
      @(negedge clk);
    end
    data_in = 4'h0;
    chk({tag, "_gap.ce"},   32'(chip_enable), 1);
    chk({tag, "_rvld7"},    32'(rd_valid),    1);
    chk({tag, "_rd7"},      32'(rd_data),     32'(base + 4'd7));
  endtask

  task automatic write_txn(input string tag, input logic [23:0] a, input logic [11:0] d, input int nn);
    io({tag, "_cmd0"}, 1'b0, 4'hF, 4'h3); @(negedge clk);
    io({tag, "_cmd1"}, 1'b0, 4'hF, 4'h8); @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      io($sformatf("%s_addr%0d", tag, i), 1'b0, 4'hF, a[23-4*i -: 4]); @(negedge clk);
    end
    for (int k = 0; k < nn; k++) begin
      io($sformatf("%s_data%0d", tag, k), 1'b0, 4'hF, d[4*k +: 4]); @(negedge clk);
    end
    chk({tag, "_gap.ce"}, 32'(chip_enable), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    int ovr;
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check_rst("t1_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_init("t1_init");

    rd_req = 1'b1; rd_addr = 24'h000123;
    @(negedge clk);
    rd_req = 1'b0;
    wait_ce_low("t2_start", 10, n);
    chk("t2_latency", 32'(n), 1);
    read_txn("t2", 24'h000123, 4'h0);
    repeat (3) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 5; i++) begin
          wr_valid = 1'b1; wr_addr = t3a[i]; wr_data = t3d[i];
          chk($sformatf("t3_ready%0d", i), 32'(wr_ready), (i < 4) ? 1 : 0);
          for (int g = 0; g < 50 && !wr_ready; g++) @(negedge clk);
          @(negedge clk);
        end
        wr_valid = 1'b0;
      end
      begin
        int m;
        for (int i = 0; i < 5; i++) begin
          wait_ce_low($sformatf("t3_w%0d", i), 40, m);
          write_txn($sformatf("t3_w%0d", i), t3a[i], 12'(t3d[i]), 1);
        end
      end
    join
    repeat (3) @(negedge clk);

    rd_req = 1'b1; rd_addr = 24'h0ABCDE;
    wr_valid = 1'b1; wr_addr = 24'h000777; wr_data = 4'h6;
    @(negedge clk);
    rd_req = 1'b0; wr_valid = 1'b0;
    ovr = 0;
    fork
      begin
        int m;
        wait_ce_low("t4_rd_start", 10, m);
        chk("t4_rd_latency", 32'(m), 1);
        read_txn("t4_rd", 24'h0ABCDE, 4'h5);
        wait_ce_low("t4_wr_start", 10, m);
        chk("t4_wr_after_gap", 32'(m), 1);
        write_txn("t4_wr", 24'h000777, 12'h006, 1);
      end
      begin
        repeat (6) @(negedge clk);
        rd_req = 1'b1; rd_addr = 24'h000555;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (i == 0) rd_req = 1'b0;
          if (rd_overrun) ovr++;
        end
      end
    join
    chk("t4_overrun_pulses", 32'(ovr), 1);
    repeat (3) @(negedge clk);

    rd_req = 1'b1; rd_addr = 24'h000042;
    wr_valid = 1'b1; wr_addr = 24'h000099; wr_data = 4'hC;
    @(negedge clk);
    rd_req = 1'b0; wr_valid = 1'b0;
    wait_ce_low("t5_start", 10, n);
    repeat (8) @(negedge clk);
    io("t5_in_dummy", 1'b0, 4'h0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check_rst("t5_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_init("t5_init");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!chip_enable || rd_valid) seen++;
    end
    chk("t5_fifo_and_read_cleared", 32'(seen), 0);

    fork
      begin
        for (int i = 0; i < 3; i++) begin
          wr_valid = 1'b1; wr_addr = 24'h000010 + 24'(i); wr_data = 4'(i + 1);
          @(negedge clk);
        end
        wr_valid = 1'b0;
      end
      begin
        int m;
`ifdef QSPI_WRITE_BURST_EN
        wait_ce_low("t6_burst", 10, m);
        write_txn("t6_burst", 24'h000010, 12'h321, 3);
`else
        for (int i = 0; i < 3; i++) begin
          wait_ce_low($sformatf("t6_w%0d", i), 20, m);
          write_txn($sformatf("t6_w%0d", i), 24'h000010 + 24'(i), 12'(i + 1), 1);
        end
`endif
      end
    join
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
